// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter that shares a single-port command memory between two REQ/ACK requesters.
// It runs one access per grant, waits out the memory read latency, and returns registered read data.
module mem_rr_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  req_a_i,
    input  logic                  req_b_i,
    input  logic                  rw_a_i,
    input  logic                  rw_b_i,
    input  logic [ADDR_WIDTH-1:0] addr_a_i,
    input  logic [ADDR_WIDTH-1:0] addr_b_i,
    input  logic [DATA_WIDTH-1:0] wdata_a_i,
    input  logic [DATA_WIDTH-1:0] wdata_b_i,
    output logic                  ack_a_o,
    output logic                  ack_b_o,
    output logic                  gnt_a_o,
    output logic                  gnt_b_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rdata_valid_o,
    output logic                  mem_en_o,
    output logic                  mem_rw_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  busy_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

    localparam logic [3:0] RD_LAT = 4'(RD_LATENCY);

    state_t                state_q;
    logic                  last_b_q;
    logic                  win_b_q;
    logic [3:0]            cnt_q;
    logic                  ack_a_q, ack_b_q;
    logic                  gnt_a_q, gnt_b_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rdata_valid_q;
    logic                  mem_en_q, mem_rw_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;

    // B wins only if A is idle, or on a tie when A was the previous winner.
    logic pick_b_d;
    logic any_req_d;
    assign pick_b_d  = req_b_i & (~req_a_i | ~last_b_q);
    assign any_req_d = req_a_i | req_b_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= IDLE;
            last_b_q      <= 1'b1;
            win_b_q       <= 1'b0;
            cnt_q         <= 4'd0;
            ack_a_q       <= 1'b0;
            ack_b_q       <= 1'b0;
            gnt_a_q       <= 1'b0;
            gnt_b_q       <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_rw_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req_d) begin
                        win_b_q     <= pick_b_d;
                        last_b_q    <= pick_b_d;
                        gnt_a_q     <= ~pick_b_d;
                        gnt_b_q     <= pick_b_d;
                        mem_rw_q    <= pick_b_d ? rw_b_i : rw_a_i;
                        mem_addr_q  <= pick_b_d ? addr_b_i : addr_a_i;
                        mem_wdata_q <= pick_b_d ? wdata_b_i : wdata_a_i;
                        mem_en_q    <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en_q <= 1'b0;
                    if (mem_rw_q) begin
                        ack_a_q <= ~win_b_q;
                        ack_b_q <= win_b_q;
                        state_q <= DONE;
                    end else begin
                        cnt_q   <= RD_LAT;
                        state_q <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (cnt_q == 4'd1) begin
                        rdata_q       <= mem_rdata_i;
                        rdata_valid_q <= 1'b1;
                        ack_a_q       <= ~win_b_q;
                        ack_b_q       <= win_b_q;
                        cnt_q         <= 4'd0;
                        state_q       <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    ack_a_q       <= 1'b0;
                    ack_b_q       <= 1'b0;
                    rdata_valid_q <= 1'b0;
                    gnt_a_q       <= 1'b0;
                    gnt_b_q       <= 1'b0;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack_a_o       = ack_a_q;
    assign ack_b_o       = ack_b_q;
    assign gnt_a_o       = gnt_a_q;
    assign gnt_b_o       = gnt_b_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign mem_en_o      = mem_en_q;
    assign mem_rw_o      = mem_rw_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: directed scenarios followed by random two-port traffic,
// checked against a transaction-level model of arbitration, latency and memory contents.
module tb_mem_rr_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int L  = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_a, req_b, rw_a, rw_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic          ack_a, ack_b, gnt_a, gnt_b;
    logic [DW-1:0] rdata;
    logic          rdata_valid, mem_en, mem_rw, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int vectors     = 0;
    int miscompares = 0;
    int txn_no      = 0;

    mem_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(L)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_a_i(req_a), .req_b_i(req_b), .rw_a_i(rw_a), .rw_b_i(rw_b),
        .addr_a_i(addr_a), .addr_b_i(addr_b), .wdata_a_i(wdata_a), .wdata_b_i(wdata_b),
        .ack_a_o(ack_a), .ack_b_o(ack_b), .gnt_a_o(gnt_a), .gnt_b_o(gnt_b),
        .rdata_o(rdata), .rdata_valid_o(rdata_valid),
        .mem_en_o(mem_en), .mem_rw_o(mem_rw), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_fn(input logic [AW-1:0] a);
        return a ^ 8'h83;
    endfunction

    // Memory device: writes land on the strobe edge, read data appears L edges after the strobe.
    logic [DW-1:0] dev_mem [256];
    bit            dev_wr  [256];
    logic [DW-1:0] rd_pipe [L];
    always @(posedge clk) begin
        if (mem_en && mem_rw) begin
            dev_mem[mem_addr] <= mem_wdata;
            dev_wr[mem_addr]  <= 1'b1;
        end
        rd_pipe[0] <= (mem_en && !mem_rw) ?
                      (dev_wr[mem_addr] ? dev_mem[mem_addr] : init_fn(mem_addr)) : 8'hEE;
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[L-1];

    // Reference model state
    logic [DW-1:0] ref_mem [256];
    bit            ref_last_b;
    logic [DW-1:0] exp_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, {ack_a, ack_b, gnt_a, gnt_b, rdata_valid, mem_en, mem_rw, busy}, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
    endtask

    task automatic new_req(input bit b);
        if (b) begin
            req_b = 1'b1; rw_b = 1'($urandom_range(0, 1));
            addr_b = 8'($urandom_range(0, 15)); wdata_b = 8'($urandom);
        end else begin
            req_a = 1'b1; rw_a = 1'($urandom_range(0, 1));
            addr_a = 8'($urandom_range(0, 15)); wdata_a = 8'($urandom);
        end
    endtask

    // Called in an IDLE cycle with at least one request driven; returns in the following IDLE cycle.
    task automatic serve(input bit drop, output bit wb);
        logic          rw;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        wb = req_b && (!req_a || !ref_last_b);
        rw = wb ? rw_b : rw_a;
        a  = wb ? addr_b : addr_a;
        wd = wb ? wdata_b : wdata_a;
        step();
        chk("issue_en", mem_en, 1);
        chk("issue_rw", mem_rw, rw);
        chk("issue_addr", mem_addr, a);
        if (rw) chk("issue_wdata", mem_wdata, wd);
        chk("issue_gnt", {gnt_a, gnt_b}, {!wb, wb});
        chk("issue_ack", {ack_a, ack_b}, 0);
        chk("issue_busy", busy, 1);
        if (drop) begin
            if (wb) req_b = 1'b0; else req_a = 1'b0;
        end
        if (!rw) begin
            for (int k = 0; k < L; k++) begin
                step();
                chk("wait_en", mem_en, 0);
                chk("wait_gnt", {gnt_a, gnt_b}, {!wb, wb});
                chk("wait_ack", {ack_a, ack_b, rdata_valid}, 0);
            end
        end
        step();
        if (rw) ref_mem[a] = wd;
        else exp_rdata = ref_mem[a];
        ref_last_b = wb;
        chk("done_ack", {ack_a, ack_b}, {!wb, wb});
        chk("done_valid", rdata_valid, !rw);
        chk("done_rdata", rdata, exp_rdata);
        chk("done_en", mem_en, 0);
        chk("done_gnt", {gnt_a, gnt_b}, {!wb, wb});
        chk("done_addr", mem_addr, a);
        step();
        chk("idle_ctl", {ack_a, ack_b, gnt_a, gnt_b, rdata_valid, mem_en, busy}, 0);
        chk("idle_rdata", rdata, exp_rdata);
        txn_no++;
        $display("txn %0d: port %s %s addr=%02h data=%02h", txn_no, wb ? "B" : "A",
                 rw ? "write" : "read ", a, rw ? wd : exp_rdata);
    endtask

    initial begin
        bit wb;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_fn(8'(i));
        ref_last_b = 1'b1;
        exp_rdata  = '0;
        rst_n = 1'b0;
        req_a = 0; req_b = 0; rw_a = 0; rw_b = 0;
        addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0;
        #1;
        check_zero("reset");
        step(); step();
        rst_n = 1'b1;
        step();

        // Single write on A
        req_a = 1; rw_a = 1; addr_a = 8'h12; wdata_a = 8'h5A;
        serve(1'b0, wb);
        req_a = 0;

        // Single read on B, data must be held afterwards
        req_b = 1; rw_b = 0; addr_b = 8'h40;
        serve(1'b0, wb);
        req_b = 0;
        chk("read_c3", rdata, 8'hC3);
        step(); step();
        chk("read_hold", rdata, 8'hC3);

        // Tie after reset-state arbitration: A, B, A with requests held
        req_a = 1; rw_a = 1; addr_a = 8'h01; wdata_a = 8'h11;
        req_b = 1; rw_b = 0; addr_b = 8'h01;
        repeat (3) serve(1'b0, wb);
        req_a = 0; req_b = 0;
        step();

        // Back-to-back writes from A only
        req_a = 1; rw_a = 1;
        for (int i = 0; i < 3; i++) begin
            addr_a = 8'(8'h20 + i); wdata_a = 8'(8'hA0 + i);
            serve(1'b0, wb);
        end
        req_a = 0;

        // Early drop: A read with REQ released during ISSUE
        req_a = 1; rw_a = 0; addr_a = 8'h21;
        serve(1'b1, wb);
        chk("drop_req", req_a, 0);

        // Asynchronous reset during WAIT_RD
        req_a = 1; rw_a = 0; addr_a = 8'h05;
        step(); step();
        chk("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_zero("midrd");
        req_a = 0;
        for (int k = 0; k < L + 2; k++) begin
            step();
            check_zero("midrd_hold");
        end
        rst_n = 1'b1;
        ref_last_b = 1'b1;
        exp_rdata  = '0;
        step();
        req_a = 1; rw_a = 1; addr_a = 8'h33; wdata_a = 8'h77;
        serve(1'b0, wb);
        req_a = 0;

        // Random two-port traffic
        for (int it = 0; it < 300; it++) begin
            if (!req_a && !req_b) begin
                step();
                chk("rand_idle", {busy, mem_en, ack_a, ack_b}, 0);
                if ($urandom_range(0, 1) == 1) new_req(1'b0);
                if ($urandom_range(0, 1) == 1) new_req(1'b1);
            end else begin
                serve($urandom_range(0, 7) == 0, wb);
                if (wb) begin
                    req_b = 1'b0;
                    if ($urandom_range(0, 1) == 1) new_req(1'b1);
                    if (!req_a && $urandom_range(0, 2) == 0) new_req(1'b0);
                end else begin
                    req_a = 1'b0;
                    if ($urandom_range(0, 1) == 1) new_req(1'b0);
                    if (!req_b && $urandom_range(0, 2) == 0) new_req(1'b1);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_rr_arbiter.md
# mem_rr_arbiter

Two-requester round-robin arbiter that shares the single-port command memory between the transfer controller (port A) and a second host/debug requester (port B). It captures one request, drives exactly one memory access cycle, waits out the fixed read latency, and returns an acknowledge with registered read data to the winning requester. Both requesters see a simple REQ/ACK handshake and never touch the memory pins directly.

## Interface
- ADDR_WIDTH, 8, memory address width
- DATA_WIDTH, 8, memory data width
- RD_LATENCY, 1, edges from memory sampling MEM_EN to valid MEM_RDATA; legal range 1..15
- CLK  in  1  clock, rising-edge
- RESET_N  in  1  one clock; reset is asynchronous and active-low
- REQ_A / REQ_B  in  1  request, held high until ACK
- RW_A / RW_B  in  1  1 = write, 0 = read
- ADDR_A / ADDR_B  in  ADDR_WIDTH  access address
- WDATA_A / WDATA_B  in  DATA_WIDTH  write data
- ACK_A / ACK_B  out  1  one-cycle completion pulse
- GNT_A / GNT_B  out  1  port owns the memory (ISSUE through DONE)
- RDATA  out  DATA_WIDTH  captured read data, shared by both ports
- RDATA_VALID  out  1  high with ACK of a read
- MEM_EN  out  1  memory access strobe, one cycle per transaction
- MEM_RW  out  1  1 = write
- MEM_ADDR  out  ADDR_WIDTH  registered address
- MEM_WDATA  out  DATA_WIDTH  registered write data
- MEM_RDATA  in  DATA_WIDTH  memory read data
- BUSY  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT_RD, DONE. All outputs registered, decoded from state (Moore).
- IDLE: sample REQ_A/REQ_B each edge. Only one high -> that port wins. Both high -> port other than LAST_GRANT wins. Neither -> stay IDLE.
- On win: capture winner's RW/ADDR/WDATA into MEM_RW/MEM_ADDR/MEM_WDATA, set GNT_x, update LAST_GRANT, go ISSUE.
- ISSUE: MEM_EN=1 exactly one cycle. Write -> DONE. Read -> WAIT_RD, load latency counter with RD_LATENCY.
- WAIT_RD: decrement counter each cycle; on edge where counter reaches 1, capture MEM_RDATA into RDATA and go DONE. Occupies exactly RD_LATENCY cycles.
- DONE: ACK_x=1 for winner; RDATA_VALID=1 if read; GNT_x stays 1; next state IDLE unconditionally.
- REQ dropped mid-transaction: ignored; transaction completes and ACK still pulses.
- REQ still high in the IDLE cycle after DONE: treated as a new request (back-to-back allowed); round-robin still applies.
- RDATA holds last read value until next read capture; writes do not change it.
- Reset (RESET_N low, any time, async): state=IDLE, all outputs 0, RDATA=0, counter=0, LAST_GRANT=B (A wins the first tie). In-flight transaction is abandoned, no ACK.

## Timing
- Cycle 0 = IDLE cycle in which REQ is sampled high.
- Write: ISSUE (MEM_EN=1) cycle 1, ACK cycle 2. Request-to-ACK latency 2 cycles; IDLE cycle 3.
- Read: ISSUE cycle 1, WAIT_RD cycles 2..RD_LATENCY+1, DONE cycle RD_LATENCY+2 with ACK, RDATA_VALID and valid RDATA.
- Minimum transaction period: write 3 cycles, read RD_LATENCY+3 cycles (includes IDLE).
- Both ports continuously requesting: grants strictly alternate; worst-case wait for a port = one other transaction plus its own.
- MEM_ADDR/MEM_WDATA/MEM_RW stable from ISSUE through DONE; MEM_EN never high outside ISSUE.
- GNT_A and GNT_B never high simultaneously; ACK never outside DONE.

## Test plan
- Reset: RESET_N low mid-read (WAIT_RD) -> all outputs 0 same cycle, no ACK, next REQ_A starts cleanly from IDLE.
- Single write: REQ_A=1, RW_A=1, ADDR_A=0x12, WDATA_A=0x5A at cycle 0 -> MEM_EN=1, MEM_RW=1, MEM_ADDR=0x12, MEM_WDATA=0x5A at cycle 1; ACK_A=1 at cycle 2, RDATA_VALID=0.
- Single read, RD_LATENCY=3: REQ_B read ADDR_B=0x40, memory model returns 0xC3 -> MEM_EN cycle 1 only, ACK_B and RDATA_VALID cycle 5, RDATA=0xC3, held after ACK.
- Tie after reset: REQ_A and REQ_B high together at cycle 0 and held -> A served first, then B, then A; GNT never overlaps.
- Back-to-back single port: REQ_A held high across 3 writes, B idle -> A served each time, ACK_A every 3 cycles.
- Early drop: REQ_A read, REQ_A deasserted in ISSUE -> transaction completes, ACK_A and RDATA_VALID still pulse at cycle RD_LATENCY+2.
